// File: rtl/vscpu_pkg.sv
// Shared constants for the VSCPU bus responder: data width, I/O window offsets, OUT_STAT bits.
package vscpu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] OFF_OUT_DATA = 4'd0;
  localparam logic [3:0] OFF_OUT_STAT = 4'd1;
  localparam logic [3:0] OFF_IN_DATA  = 4'd2;
  localparam logic [3:0] OFF_IN_STAT  = 4'd3;
  localparam logic [3:0] OFF_CYCLE    = 4'd4;

  // Count occupies the low bits, below STAT_EMPTY
  localparam int STAT_OVF   = 5;
  localparam int STAT_FULL  = 4;
  localparam int STAT_EMPTY = 3;

endpackage

// File: rtl/vscpu_tx_fifo.sv
// Synchronous TX FIFO, head visible combinationally from stored words; pop only when non-empty.
// Push when full is accepted only alongside a pop, otherwise dropped and flagged on ovf.
module vscpu_tx_fifo
  import vscpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              ovf
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign ovf      = push & full & ~pop_ok;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vscpu_bus_responder.sv
// VSCPU memory responder: RAM below IO_BASE, TX FIFO / RX mailbox / cycle counter above; 1-cycle reads.
// Never stalls the CPU; TX is drained by tx_ready, RX is held off via rx_ready while the mailbox is full.
module vscpu_bus_responder
  import vscpu_pkg::*;
#(
  parameter int                ADDR_W     = 14,
  parameter logic [ADDR_W-1:0] IO_BASE    = 14'h3FF0,
  parameter int                FIFO_DEPTH = 4,
  parameter int                FIFO_AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] addr_toRAM,
  input  logic [DATA_W-1:0] data_toRAM,
  output logic [DATA_W-1:0] data_fromRAM,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  logic [DATA_W-1:0] mem [int'(IO_BASE)];
  logic              is_io;
  logic [3:0]        io_off;
  logic              wr_io;
  logic [DATA_W-1:0] rd_dat;
  logic [DATA_W-1:0] stat;
  logic [DATA_W-1:0] cycle;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              ovf;
  logic              ovf_set;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_AW:0]  fifo_count;

  assign is_io    = (addr_toRAM >= IO_BASE);
  assign io_off   = 4'(addr_toRAM - IO_BASE);
  assign wr_io    = wrEn & is_io;
  assign tx_valid = ~fifo_empty;
  assign rx_ready = ~in_valid;

  vscpu_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_io && (io_off == OFF_OUT_DATA)),
    .push_data (data_toRAM),
    .pop       (tx_ready),
    .pop_data  (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .ovf       (ovf_set)
  );

  always_comb begin
    stat                = '0;
    stat[STAT_OVF]      = ovf;
    stat[STAT_FULL]     = fifo_full;
    stat[STAT_EMPTY]    = fifo_empty;
    stat[FIFO_AW:0]     = fifo_count;
  end

  // Reads are pure: nothing here changes state, so stray addresses are safe
  always_comb begin
    rd_dat = '0;
    if (!is_io) begin
      rd_dat = mem[addr_toRAM];
    end else begin
      case (io_off)
        OFF_OUT_STAT: rd_dat = stat;
        OFF_IN_DATA:  rd_dat = in_data;
        OFF_IN_STAT:  rd_dat = {{(DATA_W-1){1'b0}}, in_valid};
        OFF_CYCLE:    rd_dat = cycle;
        default:      rd_dat = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn && !is_io) mem[addr_toRAM] <= data_toRAM;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_fromRAM <= '0;
      cycle        <= '0;
      ovf          <= 1'b0;
      in_valid     <= 1'b0;
      in_data      <= '0;
    end else begin
      data_fromRAM <= rd_dat;
      cycle        <= cycle + 1'b1;
      if (ovf_set) ovf <= 1'b0 | 1'b1;
      else if (wr_io && (io_off == OFF_OUT_STAT)) ovf <= 1'b0;
      // A capture can only happen while empty, so it never races a clear of a live word
      if (rx_valid && !in_valid) begin
        in_data  <= rx_data;
        in_valid <= 1'b1;
      end else if (wr_io && (io_off == OFF_IN_STAT)) begin
        in_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vscpu_bus_responder.sv
// Directed and random checks of vscpu_bus_responder against a queue/array model of the bus map.
module tb_vscpu_bus_responder;

  localparam logic [13:0] IO_BASE = 14'h3FF0;
  localparam int          DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wrEn = 1'b0;
  logic [13:0] addr_toRAM = '0;
  logic [31:0] data_toRAM = '0;
  logic [31:0] data_fromRAM;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  vscpu_bus_responder dut (
    .clk          (clk),
    .rst          (rst),
    .wrEn         (wrEn),
    .addr_toRAM   (addr_toRAM),
    .data_toRAM   (data_toRAM),
    .data_fromRAM (data_fromRAM),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
  );

  always #5 clk = ~clk;

  int n_eval = 0;
  int n_fail = 0;

  // Reference model
  logic [31:0] ram [int];
  logic [31:0] q [$];
  bit          m_ovf;
  bit          m_inv;
  logic [31:0] m_ind;
  logic [31:0] m_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_inv = 0;
    m_ind = '0;
    m_cyc = '0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".tx_valid"}, {31'b0, tx_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) chk({tag, ".tx_data"}, tx_data, q[0]);
    chk({tag, ".rx_ready"}, {31'b0, rx_ready}, {31'b0, !m_inv});
  endtask

  // One CPU access per clock; prediction uses the state before the edge
  task automatic step(input string tag, input bit wr, input logic [13:0] a, input logic [31:0] d,
                      input bit txr, input bit rxv, input logic [31:0] rxd);
    logic [31:0] exp;
    bit          known;
    bit          io;
    int          off;
    int          sz;
    bit          pop;
    wrEn = wr; addr_toRAM = a; data_toRAM = d;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    io    = (a >= IO_BASE);
    off   = io ? int'(a) - int'(IO_BASE) : -1;
    sz    = q.size();
    known = 1;
    exp   = '0;
    if (!io) begin
      known = ram.exists(int'(a));
      if (known) exp = ram[int'(a)];
    end else begin
      case (off)
        1: exp = (m_ovf ? 32 : 0) + (sz == DEPTH ? 16 : 0) + (sz == 0 ? 8 : 0) + sz;
        2: exp = m_ind;
        3: exp = {31'b0, m_inv};
        4: exp = m_cyc;
        default: exp = '0;
      endcase
    end
    @(posedge clk);
    #1;
    if (wr && !io) ram[int'(a)] = d;
    pop = txr && (sz > 0);
    if (pop) void'(q.pop_front());
    if (wr && off == 0) begin
      if (sz == DEPTH && !pop) m_ovf = 1;
      else q.push_back(d);
    end
    if (wr && off == 1) m_ovf = 0;
    if (rxv && !m_inv) begin
      m_ind = rxd;
      m_inv = 1;
    end else if (wr && off == 3) begin
      m_inv = 0;
    end
    m_cyc = m_cyc + 1;
    if (known) chk({tag, ".rd"}, data_fromRAM, exp);
    check_outs(tag);
  endtask

  task automatic do_reset();
    wrEn = 0; rx_valid = 0;
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    chk("rst.data_fromRAM", data_fromRAM, 32'h0);
    chk("rst.tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst.rx_ready", {31'b0, rx_ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] v1;
    logic [31:0] v2;
    logic [13:0] ra;

    do_reset();

    // RAM write, read-back, and read-during-write returning the old word
    step("ram_wr", 1, 14'h0010, 32'hDEADBEEF, 0, 0, 0);
    step("ram_rd", 0, 14'h0010, 0, 0, 0, 0);
    chk("ram_rd.val", data_fromRAM, 32'hDEADBEEF);
    step("ram_rdw", 1, 14'h0010, 32'h1, 0, 0, 0);
    chk("ram_rdw.old", data_fromRAM, 32'hDEADBEEF);
    step("ram_rd2", 0, 14'h0010, 0, 0, 0, 0);
    chk("ram_rd2.new", data_fromRAM, 32'h1);

    // Overfill the TX FIFO, then drain it
    for (int i = 0; i < 5; i++) step("tx_fill", 1, IO_BASE, 32'hA1 + i, 0, 0, 0);
    step("tx_stat", 0, IO_BASE + 14'd1, 0, 0, 0, 0);
    chk("tx_stat.ovf_full", data_fromRAM, 32'h34);
    for (int i = 0; i < 4; i++) begin
      chk("tx_drain.data", tx_data, 32'hA1 + i);
      chk("tx_drain.valid", {31'b0, tx_valid}, 32'h1);
      step("tx_drain", 0, IO_BASE + 14'd5, 0, 1, 0, 0);
    end
    chk("tx_drain.done", {31'b0, tx_valid}, 32'h0);

    // Clear ovf, then push into a full FIFO while popping
    step("ovf_clr", 1, IO_BASE + 14'd1, 32'hFFFF, 0, 0, 0);
    step("ovf_rd", 0, IO_BASE + 14'd1, 0, 0, 0, 0);
    chk("ovf_rd.empty", data_fromRAM, 32'h08);
    for (int i = 0; i < 4; i++) step("tx_fill2", 1, IO_BASE, 32'hB0 + i, 0, 0, 0);
    step("tx_pushpop", 1, IO_BASE, 32'hB4, 1, 0, 0);
    step("tx_pp_stat", 0, IO_BASE + 14'd1, 0, 0, 0, 0);
    chk("tx_pp_stat.full_noovf", data_fromRAM, 32'h14);
    chk("tx_pp_stat.head", tx_data, 32'hB1);

    // RX mailbox: capture, hold-off, clear, second capture
    step("rx_cap", 0, IO_BASE + 14'd5, 0, 0, 1, 32'h1234);
    chk("rx_cap.rdy", {31'b0, rx_ready}, 32'h0);
    step("rx_stat", 0, IO_BASE + 14'd3, 0, 0, 1, 32'h5678);
    chk("rx_stat.val", data_fromRAM, 32'h1);
    step("rx_data", 0, IO_BASE + 14'd2, 0, 0, 1, 32'h5678);
    chk("rx_data.val", data_fromRAM, 32'h1234);
    step("rx_clr", 1, IO_BASE + 14'd3, 0, 0, 1, 32'h5678);
    chk("rx_clr.rdy", {31'b0, rx_ready}, 32'h1);
    step("rx_cap2", 0, IO_BASE + 14'd5, 0, 0, 1, 32'h5678);
    step("rx_data2", 0, IO_BASE + 14'd2, 0, 0, 0, 0);
    chk("rx_data2.val", data_fromRAM, 32'h5678);

    // Cycle counter spacing and wrap
    step("cyc_t0", 0, IO_BASE + 14'd4, 0, 0, 0, 0);
    v1 = data_fromRAM;
    for (int i = 0; i < 9; i++) step("cyc_idle", 0, IO_BASE + 14'd6, 0, 0, 0, 0);
    step("cyc_t10", 0, IO_BASE + 14'd4, 0, 0, 0, 0);
    v2 = data_fromRAM;
    chk("cyc.delta10", v2 - v1, 32'd10);
    force dut.cycle = 32'hFFFF_FFFA;
    release dut.cycle;
    m_cyc = 32'hFFFF_FFFA;
    for (int i = 0; i < 8; i++) begin
      step("cyc_wrap", 0, IO_BASE + 14'd4, 0, 0, 0, 0);
      if (i == 6) chk("cyc_wrap.zero", data_fromRAM, 32'h0);
    end

    // Randomised mix over RAM and the whole I/O window
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 14'($urandom_range(0, 15));
        1:       ra = 14'h3FE8 + 14'($urandom_range(0, 7));
        default: ra = IO_BASE + 14'($urandom_range(0, 15));
      endcase
      step("rand", $urandom_range(0, 2) == 0, ra, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom);
    end

    // Reset mid-operation discards queued TX words and mailbox
    step("pre_rst_rx", 0, IO_BASE + 14'd5, 0, 0, 1, 32'hCAFE);
    step("pre_rst_clr", 1, IO_BASE + 14'd1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("pre_rst_fill", 1, IO_BASE, 32'hC0 + i, 0, 0, 0);
    chk("pre_rst.tx_valid", {31'b0, tx_valid}, 32'h1);
    do_reset();
    step("post_rst_stat", 0, IO_BASE + 14'd1, 0, 0, 0, 0);
    chk("post_rst_stat.val", data_fromRAM, 32'h08);
    step("post_rst_cyc", 0, IO_BASE + 14'd4, 0, 0, 0, 0);
    chk("post_rst_cyc.val", data_fromRAM, 32'h1);
    step("post_rst_rx", 0, IO_BASE + 14'd3, 0, 0, 0, 0);
    chk("post_rst_rx.val", data_fromRAM, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
